// File: rtl/instr_sequencer_pkg.sv
// Shared definitions for the instruction sequencer: FSM states, the opcode
// values it needs to recognise, and opcode classification helpers.
package instr_sequencer_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEMWAIT,
        S_ALUWAIT,
        S_WRITEBACK,
        S_HALT,
        S_FAULT
    } seq_state_e;

    localparam int OPC_W = 6;

    // Opcode values shared with the control unit's opcode list.
    localparam logic [OPC_W-1:0] OP_NOP   = 6'd0;
    localparam logic [OPC_W-1:0] OP_ADDXY = 6'd1;
    localparam logic [OPC_W-1:0] OP_MULXY = 6'd5;
    localparam logic [OPC_W-1:0] OP_MULRI = 6'd6;
    localparam logic [OPC_W-1:0] OP_DIVXY = 6'd7;
    localparam logic [OPC_W-1:0] OP_DIVRI = 6'd8;
    localparam logic [OPC_W-1:0] OP_MODXY = 6'd9;
    localparam logic [OPC_W-1:0] OP_MODRI = 6'd10;
    localparam logic [OPC_W-1:0] OP_CMPXY = 6'd11;
    localparam logic [OPC_W-1:0] OP_CMPRI = 6'd12;
    localparam logic [OPC_W-1:0] OP_TSTXY = 6'd13;
    localparam logic [OPC_W-1:0] OP_TSTRI = 6'd14;
    localparam logic [OPC_W-1:0] OP_MOVXY = 6'd15;
    localparam logic [OPC_W-1:0] OP_LDR   = 6'd17;
    localparam logic [OPC_W-1:0] OP_STR   = 6'd18;
    localparam logic [OPC_W-1:0] OP_PSH   = 6'd19;
    localparam logic [OPC_W-1:0] OP_BRA   = 6'd21;
    localparam logic [OPC_W-1:0] OP_HLT   = 6'd63;

    // ALU ops that take more than one cycle and report completion via alu_done.
    function automatic logic is_multicycle(input logic [OPC_W-1:0] opc);
        return opc inside {OP_MULXY, OP_MULRI, OP_DIVXY, OP_DIVRI, OP_MODXY, OP_MODRI};
    endfunction

    // ALU ops that only update flags and never write a register.
    function automatic logic is_flag_only(input logic [OPC_W-1:0] opc);
        return opc inside {OP_CMPXY, OP_CMPRI, OP_TSTXY, OP_TSTRI};
    endfunction

endpackage

// File: rtl/seq_timeout_counter.sv
// Wait-cycle counter for memory handshakes. Flags expiry in the cycle where
// one more idle cycle would bring the count to MEM_TIMEOUT.
module seq_timeout_counter #(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic clear_i,
    input  logic incr_i,
    output logic expired_o
);

    localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Next count: clear wins over increment.
    always_comb begin
        // NOTE: defaults first so every path assigns cnt_d and no latch is inferred.
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (incr_i) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: non-blocking assignments keep all registers updating from pre-edge values.
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = incr_i && (cnt_q == CNT_W'(MEM_TIMEOUT - 1));

endmodule

// File: rtl/instr_sequencer.sv
// Multi-cycle instruction sequencer: fetches into the instruction register,
// strobes the control unit, then walks memory/ALU waits, write-back and PC update.
module instr_sequencer
    import instr_sequencer_pkg::*;
#(
    parameter int INSTR_W     = 16,
    parameter int ADDR_W      = 10,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [INSTR_W-1:0] instr_rdata,
    input  logic               imem_ready,
    input  logic               dmem_ready,
    input  logic               alu_done,
    input  logic               bra,
    input  logic               RD,
    input  logic               WR,
    input  logic               alu_en,
    input  logic               mov_en,
    input  logic               psh,
    input  logic               pop,
    input  logic               hlt,
    input  logic [ADDR_W-1:0]  branch_target,
    output logic [ADDR_W-1:0]  pc,
    output logic [INSTR_W-1:0] ir,
    output logic               imem_req,
    output logic               cu_en,
    output logic               dmem_req,
    output logic               reg_we,
    output logic               busy,
    output logic               halted,
    output logic               fault
);

    seq_state_e         state_q, state_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic [INSTR_W-1:0] ir_q, ir_d;
    logic               rd_q, rd_d;
    logic [OPC_W-1:0]   opc;
    logic               cnt_clear, cnt_incr, cnt_expired;
    logic               unused_psh;

    assign opc = ir_q[INSTR_W-1 -: OPC_W];

    // PSH needs no sequencer action; it takes the plain pc+1 path like NOP.
    assign unused_psh = psh;

    // Restart the wait count on every state change (covers entry to FETCH and
    // MEMWAIT); count only idle cycles while waiting on a memory.
    assign cnt_clear = (state_d != state_q);
    assign cnt_incr  = ((state_q == S_FETCH)   && !imem_ready) ||
                       ((state_q == S_MEMWAIT) && !dmem_ready);

    seq_timeout_counter #(
        .MEM_TIMEOUT(MEM_TIMEOUT)
    ) u_timeout (
        .clk      (clk),
        .rst      (rst),
        .clear_i  (cnt_clear),
        .incr_i   (cnt_incr),
        .expired_o(cnt_expired)
    );

    // Next-state, PC, IR and captured-RD logic.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        rd_d    = rd_q;
        unique case (state_q)
            S_IDLE: begin
                pc_d = '0;
                if (start) state_d = S_FETCH;
            end
            S_FETCH: begin
                if (imem_ready) begin
                    ir_d    = instr_rdata;
                    state_d = S_DECODE;
                end else if (cnt_expired) begin
                    state_d = S_FAULT;
                end
            end
            S_DECODE: state_d = S_EXEC;
            S_EXEC: begin
                rd_d = RD;
                if (hlt) begin
                    state_d = S_HALT;
                end else if (bra) begin
                    pc_d    = branch_target;
                    state_d = S_FETCH;
                end else if (RD || WR) begin
                    state_d = S_MEMWAIT;
                end else if (alu_en && is_multicycle(opc)) begin
                    state_d = S_ALUWAIT;
                end else if (alu_en || mov_en || pop) begin
                    state_d = S_WRITEBACK;
                end else begin
                    pc_d    = pc_q + ADDR_W'(1);
                    state_d = S_FETCH;
                end
            end
            S_MEMWAIT: begin
                if (dmem_ready) begin
                    if (rd_q) begin
                        state_d = S_WRITEBACK;
                    end else begin
                        pc_d    = pc_q + ADDR_W'(1);
                        state_d = S_FETCH;
                    end
                end else if (cnt_expired) begin
                    state_d = S_FAULT;
                end
            end
            S_ALUWAIT: begin
                if (alu_done) state_d = S_WRITEBACK;
            end
            S_WRITEBACK: begin
                pc_d    = pc_q + ADDR_W'(1);
                state_d = S_FETCH;
            end
            S_HALT:  state_d = S_HALT;
            S_FAULT: state_d = S_FAULT;
            default: state_d = S_IDLE;
        endcase
    end

    // State, PC, IR and captured-RD registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
            ir_q    <= '0;
            rd_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            rd_q    <= rd_d;
        end
    end

    assign pc       = pc_q;
    assign ir       = ir_q;
    assign imem_req = (state_q == S_FETCH);
    assign cu_en    = (state_q == S_DECODE);
    assign dmem_req = (state_q == S_MEMWAIT);
    assign reg_we   = (state_q == S_WRITEBACK) && !is_flag_only(opc);
    assign halted   = (state_q == S_HALT);
    assign fault    = (state_q == S_FAULT);
    assign busy     = !(state_q inside {S_IDLE, S_HALT, S_FAULT});

endmodule

// File: tb/tb_instr_sequencer.sv
// Self-checking bench for instr_sequencer: drives instruction memory, data
// memory, ALU and control-unit responses per instruction, and scores write-backs.
module tb_instr_sequencer;
    import instr_sequencer_pkg::*;

    localparam int INSTR_W     = 16;
    localparam int ADDR_W      = 10;
    localparam int MEM_TIMEOUT = 15;

    typedef struct packed {
        logic bra, rd, wr, alu, mov, psh, pop, hlt;
    } cu_t;

    localparam cu_t CU_NONE = 8'b0000_0000;
    localparam cu_t CU_BRA  = 8'b1000_0000;
    localparam cu_t CU_RD   = 8'b0100_0000;
    localparam cu_t CU_WR   = 8'b0010_0000;
    localparam cu_t CU_ALU  = 8'b0001_0000;
    localparam cu_t CU_MOV  = 8'b0000_1000;
    localparam cu_t CU_PSH  = 8'b0000_0100;
    localparam cu_t CU_HLT  = 8'b0000_0001;

    logic               clk = 1'b0;
    logic               rst, start, imem_ready, dmem_ready, alu_done;
    logic               bra, RD, WR, alu_en, mov_en, psh, pop, hlt;
    logic [INSTR_W-1:0] instr_rdata;
    logic [ADDR_W-1:0]  branch_target;
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] ir;
    logic               imem_req, cu_en, dmem_req, reg_we, busy, halted, fault;

    int                 n_checks = 0;
    int                 n_pass   = 0;
    int                 exp_we_q[$];
    logic [ADDR_W-1:0]  model_pc;
    int                 last_n;
    logic               prev_cu = 1'b0;

    instr_sequencer #(
        .INSTR_W    (INSTR_W),
        .ADDR_W     (ADDR_W),
        .MEM_TIMEOUT(MEM_TIMEOUT)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .instr_rdata  (instr_rdata),
        .imem_ready   (imem_ready),
        .dmem_ready   (dmem_ready),
        .alu_done     (alu_done),
        .bra          (bra),
        .RD           (RD),
        .WR           (WR),
        .alu_en       (alu_en),
        .mov_en       (mov_en),
        .psh          (psh),
        .pop          (pop),
        .hlt          (hlt),
        .branch_target(branch_target),
        .pc           (pc),
        .ir           (ir),
        .imem_req     (imem_req),
        .cu_en        (cu_en),
        .dmem_req     (dmem_req),
        .reg_we       (reg_we),
        .busy         (busy),
        .halted       (halted),
        .fault        (fault)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    // Scoreboard: every write strobe must match the oldest expected write PC.
    always @(negedge clk) begin
        if (reg_we) begin
            if (exp_we_q.size() == 0) check("reg_we_unexpected", 32'(pc), 32'hFFFF_FFFF);
            else check("reg_we_pc", 32'(pc), 32'(exp_we_q.pop_front()));
        end
        if (cu_en) check("cu_en_back_to_back", 32'(prev_cu), 32'd0);
        prev_cu = cu_en;
    end

    task automatic drive_cu(input cu_t cu);
        {bra, RD, WR, alu_en, mov_en, psh, pop, hlt} = cu;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1; start = 1'b0; imem_ready = 1'b0; dmem_ready = 1'b0; alu_done = 1'b0;
        drive_cu(CU_NONE);
        #1;
        check("rst_busy", 32'(busy), 0);
        check("rst_strobes", {imem_req, cu_en, dmem_req, reg_we, halted, fault}, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("idle_pc", 32'(pc), 0);
        check("idle_ir", 32'(ir), 0);
        check("idle_outputs", {busy, imem_req, cu_en, dmem_req, reg_we, halted, fault}, 0);
        model_pc = '0;
    endtask

    task automatic do_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("start_fetch", 32'(imem_req), 1);
        check("start_busy", 32'(busy), 1);
    endtask

    // Runs one instruction from a FETCH cycle to the next FETCH (or HALT).
    task automatic exec_instr(input string name, input logic [OPC_W-1:0] opc, input cu_t cu,
                              input int imem_wait, input int mem_wait, input int alu_wait,
                              input logic [ADDR_W-1:0] target);
        logic [INSTR_W-1:0] word;
        logic [ADDR_W-1:0]  exp_pc;
        int   exp_n, exp_dmem, n, dcnt, cu_cnt;
        logic mc, flag_only, we, done;
        mc        = opc inside {OP_MULXY, OP_MULRI, OP_DIVXY, OP_DIVRI, OP_MODXY, OP_MODRI};
        flag_only = opc inside {OP_CMPXY, OP_CMPRI, OP_TSTXY, OP_TSTRI};
        we = 1'b0; exp_dmem = 0; exp_pc = model_pc + ADDR_W'(1);
        if (cu.hlt) begin
            exp_n = 3; exp_pc = model_pc;
        end else if (cu.bra) begin
            exp_n = 3; exp_pc = target;
        end else if (cu.rd || cu.wr) begin
            exp_dmem = mem_wait + 1;
            exp_n    = cu.rd ? 5 + mem_wait : 4 + mem_wait;
            we       = cu.rd;
        end else if (cu.alu && mc) begin
            exp_n = 5 + alu_wait; we = 1'b1;
        end else if (cu.alu || cu.mov || cu.pop) begin
            exp_n = 4; we = !flag_only;
        end else begin
            exp_n = 3;
        end
        if (we) exp_we_q.push_back(int'(model_pc));
        word = {opc, 10'($urandom_range(0, 1023))};
        for (int k = 0; k < imem_wait; k++) begin
            imem_ready = 1'b0;
            @(negedge clk);
            check({name, "_fetch_wait"}, {fault, imem_req}, 2'b01);
        end
        imem_ready    = 1'b1;
        instr_rdata   = word;
        branch_target = target;
        drive_cu(cu);
        dmem_ready = 1'b0; alu_done = 1'b0;
        n = 0; dcnt = 0; cu_cnt = 0; done = 1'b0;
        while (!done && n < 64) begin
            @(negedge clk);
            n++;
            if (n == 1) begin
                check({name, "_ir"}, 32'(ir), 32'(word));
                imem_ready = 1'b0;
            end
            if (cu_en) cu_cnt++;
            if (dmem_req) begin
                dmem_ready = (dcnt == mem_wait);
                dcnt++;
            end else begin
                dmem_ready = 1'b0;
            end
            alu_done = mc && cu.alu && (n == 3 + alu_wait);
            if (imem_req || halted || fault) done = 1'b1;
        end
        alu_done = 1'b0;
        check({name, "_cycles"}, 32'(n), 32'(exp_n));
        check({name, "_pc"}, 32'(pc), 32'(exp_pc));
        check({name, "_cu_en_count"}, 32'(cu_cnt), 1);
        check({name, "_dmem_req_cycles"}, 32'(dcnt), 32'(exp_dmem));
        check({name, "_halted"}, {halted, fault}, {cu.hlt, 1'b0});
        model_pc = exp_pc;
        last_n   = n;
    endtask

    initial begin
        int total;
        logic [INSTR_W-1:0] word;
        rst = 1'b1; start = 1'b0; imem_ready = 1'b0; dmem_ready = 1'b0; alu_done = 1'b0;
        instr_rdata = '0; branch_target = '0; model_pc = '0; last_n = 0;
        drive_cu(CU_NONE);
        apply_reset();

        // NOP, NOP, HLT with ready always high.
        do_start();
        exec_instr("nop0", OP_NOP, CU_NONE, 0, 0, 0, '0);
        total = last_n;
        exec_instr("nop1", OP_NOP, CU_NONE, 0, 0, 0, '0);
        total += last_n;
        exec_instr("hlt", OP_HLT, CU_HLT, 0, 0, 0, '0);
        total += last_n;
        check("halt_cycle", 32'(total), 9);
        start = 1'b1;
        repeat (4) @(negedge clk);
        start = 1'b0;
        check("halt_sticky", {halted, busy, imem_req}, 3'b100);
        check("halt_pc", 32'(pc), 2);

        // Mixed instruction stream.
        apply_reset();
        do_start();
        exec_instr("bra5",  OP_BRA,   CU_BRA,          0, 0, 0, 10'd5);
        exec_instr("addxy", OP_ADDXY, CU_ALU,          0, 0, 0, '0);
        exec_instr("cmpxy", OP_CMPXY, CU_ALU,          0, 0, 0, '0);
        exec_instr("ldr",   OP_LDR,   CU_RD,           0, 3, 0, '0);
        exec_instr("str",   OP_STR,   CU_WR,           0, 0, 0, '0);
        exec_instr("movxy", OP_MOVXY, CU_MOV,          0, 0, 0, '0);
        exec_instr("psh",   OP_PSH,   CU_PSH,          0, 0, 0, '0);
        exec_instr("bra3ff", OP_BRA,  CU_BRA,          0, 0, 0, 10'h3FF);
        exec_instr("nopwrap", OP_NOP, CU_NONE,         0, 0, 0, '0);
        exec_instr("mulri_late", OP_MULRI, CU_ALU, MEM_TIMEOUT - 1, 0, 2, '0);

        // Instruction memory never answers: fault after MEM_TIMEOUT idle cycles.
        for (int k = 0; k < MEM_TIMEOUT - 1; k++) begin
            imem_ready = 1'b0;
            @(negedge clk);
        end
        check("timeout_edge", {fault, imem_req}, 2'b01);
        @(negedge clk);
        check("timeout_fault", {fault, busy, imem_req}, 3'b100);
        start = 1'b1;
        repeat (3) @(negedge clk);
        start = 1'b0;
        check("fault_sticky", {fault, busy}, 2'b10);
        check("fault_pc", 32'(pc), 32'(model_pc));

        // DIVRI completes, then a second DIVRI is interrupted by reset in ALUWAIT.
        apply_reset();
        do_start();
        exec_instr("divri", OP_DIVRI, CU_ALU, 0, 0, 6, '0);
        word = {OP_DIVRI, 10'h2A5};
        imem_ready = 1'b1; instr_rdata = word; drive_cu(CU_ALU); alu_done = 1'b0;
        @(negedge clk);
        imem_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("aluwait_busy", {busy, imem_req, dmem_req, reg_we}, 4'b1000);
        rst = 1'b1;
        #1;
        check("rst_mid_state", {busy, imem_req, cu_en, dmem_req, reg_we}, 0);
        check("rst_mid_pc", 32'(pc), 0);
        @(negedge clk);
        rst = 1'b0; alu_done = 1'b1;
        @(negedge clk);
        alu_done = 1'b0;
        repeat (2) @(negedge clk);
        check("post_rst_idle", {busy, halted, fault, reg_we}, 0);
        check("post_rst_pc", 32'(pc), 0);
        check("writes_outstanding", 32'(exp_we_q.size()), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule

// File: doc/instr_sequencer.md
# instr_sequencer

Multi-cycle instruction sequencer for the pocket calculator processor. It fetches instructions from instruction memory into an instruction register and pulses `CU_en` on the control unit. It then samples the control unit's registered decode outputs (`bra`, `RD`, `WR`, `alu_en`, `mov_en`, `psh`, `pop`, `hlt`) and steps the datapath through memory wait, ALU wait, write-back and PC update. It sits between instruction memory, data memory, the control unit and the register file/PC.

## Interface
- `INSTR_W`, 16: instruction width; opcode is `ir[INSTR_W-1 -: 6]`
- `ADDR_W`, 10: PC / instruction address width
- `MEM_TIMEOUT`, 15: maximum wait cycles for a memory ready before fault; must be ≥1
- `clk` in 1: the block's single clock
- `rst` in 1: reset, asynchronous, active-high
- `start` in 1: leave IDLE and begin fetching at PC 0
- `instr_rdata` in INSTR_W: instruction memory read data, valid with `imem_ready`
- `imem_ready` in 1: instruction read complete
- `dmem_ready` in 1: data memory access (LDR/STR) complete
- `alu_done` in 1: multi-cycle ALU op (MUL/DIV/MOD) complete
- `bra`, `RD`, `WR`, `alu_en`, `mov_en`, `psh`, `pop`, `hlt` in 1 each: control unit outputs, valid the cycle after `cu_en`
- `branch_target` in ADDR_W: branch/jump/return destination
- `pc` out ADDR_W: current instruction address
- `ir` out INSTR_W: instruction register
- `imem_req` out 1: instruction read request
- `cu_en` out 1: one-cycle control unit enable
- `dmem_req` out 1: data memory access request
- `reg_we` out 1: one-cycle register-file write strobe
- `busy` out 1: not in IDLE, HALT or FAULT
- `halted` out 1: in HALT
- `fault` out 1: in FAULT

## Operation
- States: IDLE, FETCH, DECODE, EXEC, MEMWAIT, ALUWAIT, WRITEBACK, HALT, FAULT.
- IDLE: `pc`=0. `start` → FETCH.
- FETCH: `imem_req`=1. On `imem_ready`, `ir`←`instr_rdata` and go to DECODE.
- DECODE: `cu_en`=1 for exactly one cycle, then EXEC.
- EXEC evaluates in priority order; first match wins:
  - `hlt` → HALT, `pc` unchanged.
  - `bra` → `pc`←`branch_target`, then FETCH.
  - `RD|WR` → MEMWAIT.
  - `alu_en` with a MUL/DIV/MOD opcode (XY or RI) → ALUWAIT.
  - `alu_en|mov_en|pop` → WRITEBACK.
  - Otherwise (NOP, PSH, untaken branch) → `pc`←`pc`+1, then FETCH.
- MEMWAIT: `dmem_req`=1. On `dmem_ready`, LDR goes to WRITEBACK; STR does `pc`+1 and goes to FETCH.
- ALUWAIT: wait for `alu_done`, then WRITEBACK. No timeout applies here.
- WRITEBACK: `reg_we`=1 unless the opcode is CMP or TST (flags only). Then `pc`+1 and FETCH.
- HALT and FAULT are sticky until `rst`. `start` is ignored in both.
- PC arithmetic is modulo 2^ADDR_W: `pc`=2^ADDR_W−1 plus 1 wraps to 0.
- Timeout:
  - The wait counter clears on entry to FETCH and MEMWAIT and increments each cycle that ready is low.
  - When the count reaches MEM_TIMEOUT with ready still low → FAULT.
  - Ready asserted in the same cycle as the limit is reached wins: normal transition, no fault.

## Timing
- Reset values: state IDLE, `pc`=0, `ir`=0, counter 0. `imem_req`, `cu_en`, `dmem_req`, `reg_we`, `busy`, `halted` and `fault` are all 0.
- All outputs are Moore, decoded from the state register only; none depend combinationally on inputs.
- Minimum cycles per instruction, with ready in the first request cycle:
  - NOP/branch: 3 (FETCH, DECODE, EXEC)
  - single-cycle ALU/MOV/POP: 4
  - STR: 4
  - LDR: 5
  - MUL/DIV/MOD: 5 + ALU wait cycles
- `cu_en` is never high in two consecutive cycles. Control inputs are sampled only in EXEC. In MEMWAIT and WRITEBACK the registered `RD`/`WR` captured in EXEC is used.
- `rst` mid-instruction: immediate return to IDLE with all strobes low. No partial write-back or PC update.
- `start` held high: acts only in IDLE.

## Structure
- Shared package holds the state enum, opcode constants (same values as the control unit's opcode list), and the `is_multicycle(opcode)` and `is_flag_only(opcode)` helpers.
- One sub-module: `seq_timeout_counter`. It takes clear/increment inputs and produces an expired output, parameterised by MEM_TIMEOUT.

## Test plan
- Reset, then `start`, with instructions NOP, NOP, HLT and ready always high → `pc` 0→1→2, `halted`=1 at cycle 9, `pc` stays 2.
- ADDXY at PC 5 → exactly one `cu_en` and one `reg_we`, `pc`=6 four cycles after FETCH entry. CMPXY → no `reg_we`.
- LDR with `dmem_ready` delayed 3 cycles → `dmem_req` high 4 cycles, then `reg_we`, `pc`+1. STR → no `reg_we`.
- BRA with `branch_target`=0x3FF, then NOP → `pc`=0x3FF, then wraps to 0.
- `imem_ready` low for 15 cycles → FAULT. Ready on the 15th cycle instead → no fault.
- DIVRI with `alu_done` after 6 cycles, with `rst` pulsed during ALUWAIT in a second run → first run writes back; second run gives IDLE, `pc`=0, no `reg_we`.
